net_edge_debounce: RTL
======================

NET_EDGE_DEBOUNCE -- requirements
Module: net_edge_debounce

Interface
- REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..4.
- REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to qualify a change, legal range 1..255.
- REQ-003 SHALL have parameter CNT_W, default 8: event counter width.
- REQ-004 SHALL have port clk, input, 1 bit: single clock; all state sampled on its rising edge.
- REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-006 SHALL have port din, input, 1 bit: asynchronous level from the upstream delayed-inverter net.
- REQ-007 SHALL have port level_o, output, 1 bit: debounced, synchronized level.
- REQ-008 SHALL have port evt_valid, output, 1 bit: edge event pending.
- REQ-009 SHALL have port evt_ready, input, 1 bit: consumer accepts the event.
- REQ-010 SHALL have port evt_rise, output, 1 bit: edge type of the pending event; 1 = rising, 0 = falling.
- REQ-011 SHALL have port evt_overrun, output, 1 bit: sticky flag, set when an event is dropped.
- REQ-012 SHALL have port count_clr, input, 1 bit: synchronous clear of evt_count; present only with the macro.
- REQ-013 SHALL have port evt_count, output, CNT_W bits: qualified-edge count; present only with the macro.

Function
- REQ-014 SHALL pass din through SYNC_STAGES flops to produce din_s.
- REQ-015 SHALL implement FSM states STABLE and QUALIFY.
  - STABLE -> QUALIFY when din_s != level_o.
  - QUALIFY -> STABLE when din_s == level_o; qualify counter cleared, no event.
- REQ-016 SHALL, in QUALIFY, count consecutive mismatch cycles.
  - On the cycle the count reaches DEBOUNCE_CYCLES: toggle level_o, generate one qualified edge, return to STABLE, clear the counter.
- REQ-017 SHALL give a latency from a clean din transition to the level_o update of SYNC_STAGES + DEBOUNCE_CYCLES clock cycles.
- REQ-018 SHALL discard glitches shorter than DEBOUNCE_CYCLES synchronized cycles; level_o unchanged, no event.
- REQ-019 SHALL hold the event in a one-entry buffer.
  - On a qualified edge with evt_valid=0, load it: evt_valid=1 and evt_rise = new level_o.
- REQ-020 SHALL complete a transfer on a cycle with evt_valid & evt_ready; evt_valid deasserts next cycle unless a new edge loads in the same cycle.
- REQ-021 SHALL, when a qualified edge and a completed transfer occur in the same cycle, load the new event with no overrun.
- REQ-022 SHALL, on a qualified edge while evt_valid=1 and evt_ready=0:
  - drop the new event;
  - set evt_overrun;
  - leave evt_rise unchanged.
- REQ-023 SHALL clear evt_overrun on the cycle after the next completed transfer, unless another drop occurs in that same cycle.
- REQ-024 SHALL hold evt_rise stable while evt_valid=1.

Reset
- REQ-025 SHALL, on rst_n=0, asynchronously force:
  - synchronizer flops 0;
  - level_o 0;
  - FSM to STABLE and qualify counter 0;
  - evt_valid 0, evt_rise 0, evt_overrun 0;
  - evt_count 0.
- REQ-026 SHALL abandon any in-progress qualification on reset; no event is generated for it.
- REQ-027 SHALL treat a din level of 1 after reset release as a normal rising change that is qualified per REQ-016.

Configuration
- REQ-028 SHALL gate the event counter with macro NET_EDGE_DEBOUNCE_CNT_EN.
  - Defined: count_clr and evt_count exist; evt_count increments on every qualified edge, including dropped ones, and saturates at all-ones.
  - count_clr clears evt_count to 0 and wins over a simultaneous edge (result 0).
  - Undefined: neither port exists and no counter logic is synthesized; all other behaviour is identical.

Structure
- REQ-029 SHALL place the FSM state enum (STABLE, QUALIFY) and edge-type constants (EDGE_FALL=0, EDGE_RISE=1) in shared package net_edge_pkg.
- REQ-030 SHALL implement the synchronizer as sub-module net_sync (parameter STAGES, ports clk, rst_n, d, q).

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=8)
- REQ-031 SHALL cover a clean rise: din 0->1, held 10 cycles, evt_ready=1 -> level_o=1 exactly 6 cycles after the change; evt_valid pulses 1 cycle with evt_rise=1; evt_count=1.
- REQ-032 SHALL cover a glitch: din high for 2 cycles -> level_o stays 0, evt_valid never asserts, evt_count=0.
- REQ-033 SHALL cover an overrun: evt_ready=0, then rise followed by fall, each held 8 cycles -> evt_valid=1 with evt_rise=1, evt_overrun=1, evt_count=2. Then evt_ready=1 for 1 cycle -> evt_valid=0 and evt_overrun=0 next cycle.
- REQ-034 SHALL cover a simultaneous transfer and new edge: evt_ready asserted on the qualifying cycle of a fall -> new event loaded with evt_rise=0, evt_overrun=0.
- REQ-035 SHALL cover reset mid-qualify: din rises, rst_n pulsed low 2 cycles after the synchronized change -> all outputs 0 immediately; after release, level_o rises 6 cycles later.
- REQ-036 SHALL cover saturation and clear: 260 edges -> evt_count=255; count_clr asserted together with an edge -> evt_count=0.

Source files
------------

// File: rtl/net_edge_pkg.sv
// Shared types and constants for the net edge debouncer.
// Optional event counter is enabled by macro NET_EDGE_DEBOUNCE_CNT_EN.
package net_edge_pkg;

   // Debounce FSM: idle on a settled level, or counting a candidate change.
   typedef enum logic {
      STABLE  = 1'b0,
      QUALIFY = 1'b1
   } state_e;

   // Edge type reported on evt_rise.
   localparam logic EDGE_FALL = 1'b0;
   localparam logic EDGE_RISE = 1'b1;

   // Width of the qualify counter; covers DEBOUNCE_CYCLES up to 255.
   localparam int unsigned QCNT_W = 8;

endpackage

// File: rtl/net_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit level.
// Part of net_edge_debounce (macro NET_EDGE_DEBOUNCE_CNT_EN not used here).
module net_sync
   import net_edge_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw level through the flop chain; oldest sample is the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/net_edge_debounce.sv
// Synchronizes and debounces a level from the delayed-inverter net and
// reports each qualified edge through a one-entry valid/ready event buffer.
// Define NET_EDGE_DEBOUNCE_CNT_EN to add the saturating edge counter
// (ports count_clr / evt_count).
module net_edge_debounce
   import net_edge_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   output logic             level_o,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic             evt_rise,
   output logic             evt_overrun
`ifdef NET_EDGE_DEBOUNCE_CNT_EN
   ,
   input  logic             count_clr,
   output logic [CNT_W-1:0] evt_count
`endif
);

   localparam logic [QCNT_W-1:0] DB_LAST = QCNT_W'(DEBOUNCE_CYCLES);

   logic              din_s;
   state_e            state_q, state_d;
   logic [QCNT_W-1:0] qcnt_q, qcnt_d;
   logic [QCNT_W-1:0] qcnt_inc;
   logic              level_q, level_d;
   logic              mismatch;
   logic              edge_qual;

   logic              valid_q, valid_d;
   logic              rise_q, rise_d;
   logic              ovr_q, ovr_d;
   logic              xfer, load, drop;

   net_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (din),
      .q    (din_s)
   );

   assign mismatch = (din_s != level_q);
   assign qcnt_inc = qcnt_q + QCNT_W'(1);

   // FSM and level state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STABLE;
         qcnt_q  <= '0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
         level_q <= level_d;
      end
   end

   // Next-state: count consecutive mismatch cycles, toggle level when the
   // count reaches DEBOUNCE_CYCLES. The first mismatch cycle is counted in
   // STABLE so a one-cycle debounce qualifies without entering QUALIFY.
   always_comb begin
      state_d   = state_q;
      qcnt_d    = qcnt_q;
      level_d   = level_q;
      edge_qual = 1'b0;
      unique case (state_q)
         STABLE: begin
            if (mismatch) begin
               if (qcnt_inc == DB_LAST) begin
                  level_d   = ~level_q;
                  edge_qual = 1'b1;
                  qcnt_d    = '0;
               end else begin
                  state_d = QUALIFY;
                  qcnt_d  = qcnt_inc;
               end
            end
         end
         QUALIFY: begin
            if (!mismatch) begin
               state_d = STABLE;
               qcnt_d  = '0;
            end else if (qcnt_inc == DB_LAST) begin
               state_d   = STABLE;
               qcnt_d    = '0;
               level_d   = ~level_q;
               edge_qual = 1'b1;
            end else begin
               qcnt_d = qcnt_inc;
            end
         end
         default: begin
            state_d = STABLE;
            qcnt_d  = '0;
         end
      endcase
   end

   assign xfer = valid_q & evt_ready;
   assign load = edge_qual & (~valid_q | xfer);
   assign drop = edge_qual & valid_q & ~evt_ready;

   // Event buffer next-state: a transfer frees the slot in the same cycle a
   // new edge may load; otherwise an edge on a full slot is dropped.
   always_comb begin
      valid_d = valid_q;
      rise_d  = rise_q;
      ovr_d   = ovr_q;
      if (load) begin
         valid_d = 1'b1;
         rise_d  = level_d ? EDGE_RISE : EDGE_FALL;
      end else if (xfer) begin
         valid_d = 1'b0;
      end
      if (drop) begin
         ovr_d = 1'b1;
      end else if (xfer) begin
         ovr_d = 1'b0;
      end
   end

   // Event buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rise_q  <= EDGE_FALL;
         ovr_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         rise_q  <= rise_d;
         ovr_q   <= ovr_d;
      end
   end

   assign level_o     = level_q;
   assign evt_valid   = valid_q;
   assign evt_rise    = rise_q;
   assign evt_overrun = ovr_q;

`ifdef NET_EDGE_DEBOUNCE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating qualified-edge counter; clear beats a simultaneous edge.
   always_comb begin
      cnt_d = cnt_q;
      if (count_clr) begin
         cnt_d = '0;
      end else if (edge_qual && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign evt_count = cnt_q;
`endif

endmodule
